// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter
// Writer side of the integer register-file write port. Results come from three
// producers: a single-cycle ALU path (no handshake) and two valid/ready
// producers (load unit "mem" and multiply/divide unit "md"). At most one
// result is accepted per cycle and written through a registered write port.
// A pending-destination scoreboard tracks outstanding long-latency ops so
// decode can stall on RAW/WAW hazards.
//
// Optional feature macro: WB_FWD_EN
//   Adds rs1Fwd/rs2Fwd/fwdData. A pending bit cleared by this cycle's
//   accepted transfer no longer raises hazardStall. The operand is instead
//   forwarded from rdData on the following cycle.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   stall              pipeline freeze (holds all state, blocks handshakes)
//   alu*               ALU result (absolute priority, no backpressure)
//   mem*, memReady     load result, valid/ready
//   md*,  mdReady      mul/div result, valid/ready
//   issue*             decode issue info for scoreboard set
//   rs1Addr, rs2Addr   decode sources for RAW check
//   rdWrite/rdAddr/rdData  registered register-file write port
//   hazardStall        decode must hold
//   pending            scoreboard vector (debug)
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            aluValid,
  input  logic [AW-1:0]   aluRd,
  input  logic [XLEN-1:0] aluData,
  input  logic            memValid,
  input  logic [AW-1:0]   memRd,
  input  logic [XLEN-1:0] memData,
  output logic            memReady,
  input  logic            mdValid,
  input  logic [AW-1:0]   mdRd,
  input  logic [XLEN-1:0] mdData,
  output logic            mdReady,
  input  logic            issueValid,
  input  logic            issueLong,
  input  logic [AW-1:0]   issueRd,
  input  logic [AW-1:0]   rs1Addr,
  input  logic [AW-1:0]   rs2Addr,
  output logic            rdWrite,
  output logic [AW-1:0]   rdAddr,
  output logic [XLEN-1:0] rdData,
  output logic            hazardStall,
  output logic [NREG-1:0] pending
`ifdef WB_FWD_EN
  ,
  output logic            rs1Fwd,
  output logic            rs2Fwd,
  output logic [XLEN-1:0] fwdData
`endif
);

  // Which of mem/md won the most recent accepted transfer.
  typedef enum logic {
    RR_MEM = 1'b0,
    RR_MD  = 1'b1
  } rr_t;

  rr_t             rr_last_r;
  rr_t             rr_last_s;
  logic            mem_grant_s;
  logic            md_grant_s;
  logic            sel_valid_s;
  logic [AW-1:0]   sel_rd_s;
  logic [XLEN-1:0] sel_data_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] eff_pend_s;
  logic [NREG-1:0] pend_s;
  logic            haz_s;
  logic            rd_write_r;
  logic [AW-1:0]   rd_addr_r;
  logic [XLEN-1:0] rd_data_r;
  logic [NREG-1:0] pending_r;

  // Handshake grants: ALU pre-empts both producers; ties go round-robin.
  always_comb begin
    mem_grant_s = 1'b0;
    md_grant_s  = 1'b0;
    if (rst || stall || aluValid) begin
      mem_grant_s = 1'b0;
      md_grant_s  = 1'b0;
    end else if (memValid && mdValid) begin
      mem_grant_s = (rr_last_r == RR_MD);
      md_grant_s  = (rr_last_r == RR_MEM);
    end else begin
      mem_grant_s = memValid;
      md_grant_s  = mdValid;
    end
  end

  assign memReady = mem_grant_s;
  assign mdReady  = md_grant_s;

  // Round-robin next state: moves only on an accepted mem/md transfer.
  always_comb begin
    rr_last_s = rr_last_r;
    case (rr_last_r)
      RR_MEM: begin
        if (md_grant_s) rr_last_s = RR_MD;
        else            rr_last_s = RR_MEM;
      end
      RR_MD: begin
        if (mem_grant_s) rr_last_s = RR_MEM;
        else             rr_last_s = RR_MD;
      end
      default: rr_last_s = RR_MD;
    endcase
  end

  // Round-robin state register; reset to md so mem wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_r <= RR_MD;
    end else if (!stall) begin
      rr_last_r <= rr_last_s;
    end
  end

  // Select the result that will be written on the next edge.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_rd_s    = {AW{1'b0}};
    sel_data_s  = {XLEN{1'b0}};
    if (stall) begin
      sel_valid_s = 1'b0;
    end else if (aluValid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = aluRd;
      sel_data_s  = aluData;
    end else if (mem_grant_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = memRd;
      sel_data_s  = memData;
    end else if (md_grant_s) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = mdRd;
      sel_data_s  = mdData;
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Registered write port; x0 results are consumed but never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_write_r <= 1'b0;
      rd_addr_r  <= {AW{1'b0}};
      rd_data_r  <= {XLEN{1'b0}};
    end else if (!stall) begin
      if (sel_valid_s && (sel_rd_s != {AW{1'b0}})) begin
        rd_write_r <= 1'b1;
        rd_addr_r  <= sel_rd_s;
        rd_data_r  <= sel_data_s;
      end else begin
        rd_write_r <= 1'b0;
      end
    end
  end

  // Scoreboard bit cleared by this cycle's accepted long-latency completion.
  always_comb begin
    clr_mask_s = {NREG{1'b0}};
    if (mem_grant_s) begin
      clr_mask_s[memRd] = 1'b1;
    end else if (md_grant_s) begin
      clr_mask_s[mdRd] = 1'b1;
    end else begin
      clr_mask_s = {NREG{1'b0}};
    end
  end

  // Hazard detection on sources and on the issuing destination (WAW).
  always_comb begin
`ifdef WB_FWD_EN
    // A completing register is forwarded next cycle instead of stalling.
    eff_pend_s = pending_r & ~clr_mask_s;
`else
    eff_pend_s = pending_r;
`endif
    haz_s = (eff_pend_s[rs1Addr] && (rs1Addr != {AW{1'b0}})) ||
            (eff_pend_s[rs2Addr] && (rs2Addr != {AW{1'b0}})) ||
            (issueValid && (issueRd != {AW{1'b0}}) && eff_pend_s[issueRd]);
  end

  assign hazardStall = haz_s;

  // Scoreboard next state: set applied after clear so set wins a collision.
  always_comb begin
    set_mask_s = {NREG{1'b0}};
    if (issueValid && issueLong && (issueRd != {AW{1'b0}}) && !haz_s) begin
      set_mask_s[issueRd] = 1'b1;
    end else begin
      set_mask_s = {NREG{1'b0}};
    end
    if (stall) begin
      pend_s = pending_r;
    end else begin
      pend_s = (pending_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NREG{1'b0}};
    end else begin
      pending_r <= pend_s;
    end
  end

  assign rdWrite = rd_write_r;
  assign rdAddr  = rd_addr_r;
  assign rdData  = rd_data_r;
  assign pending = pending_r;

`ifdef WB_FWD_EN
  assign rs1Fwd  = rd_write_r && !stall && (rd_addr_r == rs1Addr) && (rs1Addr != {AW{1'b0}});
  assign rs2Fwd  = rd_write_r && !stall && (rd_addr_r == rs2Addr) && (rs2Addr != {AW{1'b0}});
  assign fwdData = rd_data_r;
`endif

endmodule
